// File: rtl/dcc_cmd_if.sv
// Command-scheduler bus: slot table writes/clears, estop level, engine packet
// counter in; loaded command word and slot status out.
interface dcc_cmd_if #(
  parameter int NUM_SLOTS = 8,
  parameter int SLOT_W    = 3
);
  logic                 wr_en;
  logic [SLOT_W-1:0]    wr_slot;
  logic [7:0]           wr_addr;
  logic [7:0]           wr_instr;
  logic                 clr_en;
  logic [SLOT_W-1:0]    clr_slot;
  logic                 estop;
  logic [9:0]           cmd_index;
  logic [31:0]          cmd_word;
  logic [NUM_SLOTS-1:0] active_mask;
  logic                 urgent_pending;

  modport master (
    output wr_en, wr_slot, wr_addr, wr_instr, clr_en, clr_slot, estop, cmd_index,
    input  cmd_word, active_mask, urgent_pending
  );

  modport slave (
    input  wr_en, wr_slot, wr_addr, wr_instr, clr_en, clr_slot, estop, cmd_index,
    output cmd_word, active_mask, urgent_pending
  );
endinterface

// File: rtl/dcc_cmd_scheduler.sv
// DCC command scheduler: picks estop / urgent / round-robin refresh / idle per
// packet and holds the 32-bit command word stable for the packet engine.
//   state  | meaning
//   WAIT   | hold cmd_word, wait for a cmd_index change (or a queued one)
//   SELECT | arbitrate and capture the next word
//   LOAD   | present the captured word on cmd_word
module dcc_cmd_scheduler #(
  parameter int         NUM_SLOTS   = 8,
  parameter int         SLOT_W      = 3,
  parameter int         REPEAT      = 3,
  parameter int         URG_MAX     = 4,
  parameter logic [7:0] ESTOP_INSTR = 8'h61
) (
  input logic       clk,
  input logic       reset_n,
  dcc_cmd_if.slave  bus
);
  localparam int          URG_W      = $clog2(URG_MAX + 1);
  localparam logic [31:0] IDLE_WORD  = 32'h0200_FF00;
  localparam logic [31:0] ESTOP_WORD = 32'h0400_0000 | {24'h0, ESTOP_INSTR};

  typedef enum logic [1:0] {S_WAIT, S_SELECT, S_LOAD} state_t;

  state_t               state;
  logic [NUM_SLOTS-1:0] valid;
  logic [7:0]           addr_tbl  [NUM_SLOTS];
  logic [7:0]           instr_tbl [NUM_SLOTS];
  logic [2:0]           pend      [NUM_SLOTS];
  logic [SLOT_W-1:0]    rr_ptr;
  logic [URG_W-1:0]     urg_cnt;
  logic [9:0]           idx_q;
  logic                 adv_pend;
  logic [31:0]          sel_word;
  logic [31:0]          word_q;

  logic                 adv;
  logic                 pend_any;
  logic [SLOT_W-1:0]    pend_slot;
  logic                 rr_any;
  logic [SLOT_W-1:0]    rr_slot;
  logic [SLOT_W-1:0]    cand;

  assign adv = (bus.cmd_index != idx_q);

  // Descending loops so the last hit is the lowest index / nearest after rr_ptr.
  always_comb begin
    pend_any  = 1'b0;
    pend_slot = '0;
    rr_any    = 1'b0;
    rr_slot   = '0;
    cand      = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (pend[i] != 3'd0) begin
        pend_any  = 1'b1;
        pend_slot = SLOT_W'(i);
      end
    end
    for (int i = NUM_SLOTS; i >= 1; i--) begin
      cand = rr_ptr + SLOT_W'(i);
      if (valid[cand]) begin
        rr_any  = 1'b1;
        rr_slot = cand;
      end
    end
  end

  assign bus.active_mask    = valid;
  assign bus.urgent_pending = pend_any;
  assign bus.cmd_word       = word_q;

  function automatic logic [31:0] slot_word(input logic [SLOT_W-1:0] s, input logic urg);
    return {7'b0, urg, 8'(s), addr_tbl[s], instr_tbl[s]};
  endfunction

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= S_WAIT;
      valid    <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        addr_tbl[i]  <= '0;
        instr_tbl[i] <= '0;
        pend[i]      <= '0;
      end
      rr_ptr   <= '0;
      urg_cnt  <= '0;
      idx_q    <= bus.cmd_index;
      adv_pend <= 1'b0;
      sel_word <= IDLE_WORD;
      word_q   <= IDLE_WORD;
    end else begin
      idx_q <= bus.cmd_index;
      case (state)
        S_WAIT: begin
          if (adv || adv_pend) begin
            state    <= S_SELECT;
            adv_pend <= 1'b0;
          end
        end
        S_SELECT: begin
          if (adv) adv_pend <= 1'b1;
          state <= S_LOAD;
          if (bus.estop) begin
            sel_word <= ESTOP_WORD;
          end else if (pend_any && (urg_cnt < URG_W'(URG_MAX))) begin
            sel_word        <= slot_word(pend_slot, 1'b1);
            pend[pend_slot] <= pend[pend_slot] - 3'd1;
            urg_cnt         <= urg_cnt + URG_W'(1);
          end else if (rr_any) begin
            sel_word <= slot_word(rr_slot, 1'b0);
            rr_ptr   <= rr_slot;
            urg_cnt  <= '0;
          end else begin
            sel_word <= IDLE_WORD;
            urg_cnt  <= '0;
          end
        end
        S_LOAD: begin
          if (adv) adv_pend <= 1'b1;
          word_q <= sel_word;
          state  <= S_WAIT;
        end
        default: state <= S_WAIT;
      endcase
      // Table updates come last so a write overrides the SELECT decrement
      // and a clear overrides a write to the same slot.
      if (bus.wr_en) begin
        valid[bus.wr_slot]     <= 1'b1;
        addr_tbl[bus.wr_slot]  <= bus.wr_addr;
        instr_tbl[bus.wr_slot] <= bus.wr_instr;
        pend[bus.wr_slot]      <= 3'(REPEAT);
      end
      if (bus.clr_en) begin
        valid[bus.clr_slot] <= 1'b0;
        pend[bus.clr_slot]  <= 3'd0;
      end
    end
  end
endmodule

// File: tb/tb_dcc_cmd_scheduler.sv
// Directed bench for dcc_cmd_scheduler with a packet-level reference model.
module tb_dcc_cmd_scheduler;
  localparam int NS   = 8;
  localparam int SW   = 3;
  localparam int REP  = 3;
  localparam int UMAX = 4;
  localparam logic [31:0] IDLE  = 32'h0200_FF00;
  localparam logic [31:0] ESTOP = 32'h0400_0061;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  dcc_cmd_if #(.NUM_SLOTS(NS), .SLOT_W(SW)) bus ();

  dcc_cmd_scheduler #(
    .NUM_SLOTS(NS), .SLOT_W(SW), .REPEAT(REP), .URG_MAX(UMAX), .ESTOP_INSTR(8'h61)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  // reference model state
  bit          m_valid [NS];
  logic [7:0]  m_addr  [NS];
  logic [7:0]  m_instr [NS];
  int          m_pend  [NS];
  int          m_rr;
  int          m_urg;
  logic [31:0] exp_word;
  int          c_kind;   // 0 estop, 1 urgent, 2 refresh, 3 idle
  int          c_slot;
  logic [31:0] c_word;

  int n_chk = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  logic [31:0] rr_pins [6] = '{32'h0001_1121, 32'h0005_1525, 32'h0000_1020,
                               32'h0001_1121, 32'h0005_1525, 32'h0000_1020};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NS-1:0] m_mask();
    logic [NS-1:0] m = '0;
    for (int s = 0; s < NS; s++) m[s] = m_valid[s];
    return m;
  endfunction

  function automatic bit m_upend();
    bit r = 1'b0;
    for (int s = 0; s < NS; s++) if (m_pend[s] > 0) r = 1'b1;
    return r;
  endfunction

  function automatic logic [31:0] m_slot_word(input int s, input bit u);
    return (u ? 32'h0100_0000 : 32'h0) | (32'(s) << 16) |
           (32'(m_addr[s]) << 8) | 32'(m_instr[s]);
  endfunction

  task automatic model_reset();
    for (int s = 0; s < NS; s++) begin
      m_valid[s] = 1'b0; m_addr[s] = 8'h0; m_instr[s] = 8'h0; m_pend[s] = 0;
    end
    m_rr = 0; m_urg = 0; exp_word = IDLE;
  endtask

  task automatic model_choose();
    int first;
    c_kind = 3; c_slot = 0; c_word = IDLE;
    if (bus.estop) begin
      c_kind = 0; c_word = ESTOP;
    end else begin
      first = -1;
      for (int s = 0; s < NS; s++) if (m_pend[s] > 0 && first < 0) first = s;
      if (first >= 0 && m_urg < UMAX) begin
        c_kind = 1; c_slot = first; c_word = m_slot_word(first, 1'b1);
      end else begin
        first = -1;
        for (int k = 1; k <= NS; k++)
          if (m_valid[(m_rr + k) % NS] && first < 0) first = (m_rr + k) % NS;
        if (first >= 0) begin
          c_kind = 2; c_slot = first; c_word = m_slot_word(first, 1'b0);
        end
      end
    end
  endtask

  task automatic model_commit();
    case (c_kind)
      1: begin m_pend[c_slot]--; m_urg++; end
      2: begin m_rr = c_slot; m_urg = 0; end
      3: m_urg = 0;
      default: ;
    endcase
  endtask

  task automatic model_write(input int s, input logic [7:0] a, input logic [7:0] i);
    m_valid[s] = 1'b1; m_addr[s] = a; m_instr[s] = i; m_pend[s] = REP;
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      check("cmd_word", bus.cmd_word, exp_word);
      check("active_mask", 32'(bus.active_mask), 32'(m_mask()));
      check("urgent_pending", 32'(bus.urgent_pending), 32'(m_upend()));
    end
  end

  task automatic do_reset();
    @(negedge clk) reset_n = 1'b0;
    @(posedge clk) #1 model_reset();
    @(negedge clk) reset_n = 1'b1;
  endtask

  task automatic write_slot(input int s, input logic [7:0] a, input logic [7:0] i);
    @(negedge clk);
    bus.wr_en = 1'b1; bus.wr_slot = SW'(s); bus.wr_addr = a; bus.wr_instr = i;
    @(posedge clk) #1;
    bus.wr_en = 1'b0;
    model_write(s, a, i);
  endtask

  // One packet: cmd_index change, then SELECT edge, then LOAD edge.
  task automatic step(input bit col = 1'b0, input int cs = 0,
                      input logic [7:0] ca = 8'h0, input logic [7:0] ci = 8'h0);
    @(negedge clk) bus.cmd_index = bus.cmd_index + 10'd1;
    @(posedge clk) #1 model_choose();
    if (col) begin
      @(negedge clk);
      bus.wr_en = 1'b1; bus.wr_slot = SW'(cs); bus.wr_addr = ca; bus.wr_instr = ci;
    end
    @(posedge clk) #1 model_commit();
    if (col) begin
      bus.wr_en = 1'b0;
      model_write(cs, ca, ci);
    end
    @(posedge clk) #1 exp_word = c_word;
  endtask

  // Three cmd_index changes on consecutive cycles: exactly one extra packet queued.
  task automatic burst3();
    logic [31:0] w1;
    @(negedge clk) bus.cmd_index = bus.cmd_index + 10'd1;
    @(posedge clk) #1 model_choose();
    @(negedge clk) bus.cmd_index = bus.cmd_index + 10'd1;
    @(posedge clk) #1 model_commit();
    w1 = c_word;
    @(negedge clk) bus.cmd_index = bus.cmd_index + 10'd1;
    @(posedge clk) #1 exp_word = w1;
    @(posedge clk) #1 model_choose();
    @(posedge clk) #1 model_commit();
    @(posedge clk) #1 exp_word = c_word;
    repeat (5) @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    bus.wr_en = 1'b0; bus.wr_slot = '0; bus.wr_addr = '0; bus.wr_instr = '0;
    bus.clr_en = 1'b0; bus.clr_slot = '0; bus.estop = 1'b0; bus.cmd_index = '0;
    @(posedge clk) #1 model_reset();
    chk_on = 1'b1;
    @(negedge clk) reset_n = 1'b1;
    check("reset_word", bus.cmd_word, 32'h0200_FF00);
    check("reset_mask", 32'(bus.active_mask), 32'h0);
    check("reset_upend", 32'(bus.urgent_pending), 32'h0);

    // idle with no slots
    step(); check("idle_step1", bus.cmd_word, 32'h0200_FF00);
    step(); check("idle_step2", bus.cmd_word, 32'h0200_FF00);

    // single write: three urgent, then a refresh
    do_reset();
    write_slot(2, 8'h03, 8'h64);
    for (int k = 0; k < 3; k++) begin
      step(); check("urgent_slot2", bus.cmd_word, 32'h0102_0364);
    end
    check("upend_cleared", 32'(bus.urgent_pending), 32'h0);
    step(); check("refresh_slot2", bus.cmd_word, 32'h0002_0364);

    // drain to rr_ptr=0 with slots 0,1,5 valid, then round-robin
    do_reset();
    write_slot(1, 8'h11, 8'h21);
    write_slot(5, 8'h15, 8'h25);
    write_slot(0, 8'h10, 8'h20);
    for (int k = 0; k < 12; k++) step();
    check("drain_last", bus.cmd_word, 32'h0000_1020);
    for (int k = 0; k < 6; k++) begin
      step(); check("rr_order", bus.cmd_word, rr_pins[k]);
    end

    // five slots written: forced refresh after URG_MAX urgent packets
    do_reset();
    for (int s = 0; s < 5; s++) write_slot(s, 8'(8'h20 + s), 8'(8'h30 + s));
    for (int k = 0; k < 4; k++) step();
    step(); check("forced_refresh", bus.cmd_word, 32'h0001_2131);
    for (int k = 0; k < 6; k++) step();
    burst3();
    for (int k = 0; k < 10; k++) step();

    // estop mid-sequence freezes urgent progress
    do_reset();
    write_slot(2, 8'h03, 8'h64);
    step();
    @(negedge clk) bus.estop = 1'b1;
    step(); check("estop_word", bus.cmd_word, 32'h0400_0061);
    check("estop_upend", 32'(bus.urgent_pending), 32'h1);
    @(negedge clk) bus.estop = 1'b0;
    step(); check("resume_u2", bus.cmd_word, 32'h0102_0364);
    step(); check("resume_u3", bus.cmd_word, 32'h0102_0364);
    step(); check("resume_ref", bus.cmd_word, 32'h0002_0364);

    // write and clear of slot3 in the same cycle
    do_reset();
    write_slot(3, 8'h33, 8'h43);
    @(negedge clk);
    bus.wr_en = 1'b1; bus.wr_slot = 3'd3; bus.wr_addr = 8'h55; bus.wr_instr = 8'h66;
    bus.clr_en = 1'b1; bus.clr_slot = 3'd3;
    @(posedge clk) #1;
    bus.wr_en = 1'b0; bus.clr_en = 1'b0;
    model_write(3, 8'h55, 8'h66);
    m_valid[3] = 1'b0; m_pend[3] = 0;
    check("clr_wins_mask", 32'(bus.active_mask), 32'h0);

    // write colliding with the SELECT decrement restores pending
    do_reset();
    write_slot(4, 8'h44, 8'h44);
    step();
    step(1'b1, 4, 8'h44, 8'h44);
    step(); step();
    step(); check("col_refresh", bus.cmd_word, 32'h0004_4444);
    step(); check("col_urgent", bus.cmd_word, 32'h0104_4444);

    // reset in LOAD with an advance queued
    do_reset();
    write_slot(1, 8'h01, 8'h02);
    @(negedge clk) bus.cmd_index = bus.cmd_index + 10'd1;
    @(posedge clk) #1 model_choose();
    @(negedge clk) bus.cmd_index = bus.cmd_index + 10'd1;
    @(posedge clk) #1 model_commit();
    @(negedge clk) reset_n = 1'b0;
    @(posedge clk) #1 model_reset();
    check("rst_load_word", bus.cmd_word, 32'h0200_FF00);
    check("rst_load_mask", 32'(bus.active_mask), 32'h0);
    @(negedge clk) reset_n = 1'b1;
    write_slot(6, 8'h06, 8'h07);
    repeat (6) @(posedge clk);
    #1;
    check("no_stale_adv", bus.cmd_word, 32'h0200_FF00);
    check("post_rst_mask", 32'(bus.active_mask), 32'h40);

    @(negedge clk) chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
